rst_sequencer: RTL

- Parametrised power-on and reset sequencer for SoC top levels.
- Replaces the ad-hoc fixed 100-cycle reset counter and hard-coded simulation finish in each top wrapper.
- Holds N reset domains until the PLL has locked and a hold period has elapsed, then releases the domains one at a time in order.
- Re-enters reset on PLL lock loss, a debounced button press, or a software request; provides a simulation-timeout flag.

---
 rtl/rst_sequencer_pkg.sv | 10 +
 rtl/sync_debounce.sv | 40 ++++
 rtl/rst_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rst_sequencer_pkg.sv
// rst_sequencer_pkg: state encoding and default timing values shared by the reset sequencer.
package rst_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;
  localparam int          DEF_HOLD_CYCLES = 100;
  localparam logic [31:0] DEF_TIMEOUT     = 32'hf000;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: multi-flop synchroniser followed by a stability counter; dout takes a new level
// only after the synchronised input has held it for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-2:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d, diff;
  // The output flop doubles as the last synchroniser stage, so DEBOUNCE_CYCLES=1 is a plain 2-flop sync.
  if (SYNC_STAGES > 2) begin : g_chain
    assign sync_d = {sync_q[SYNC_STAGES-3:0], din};
  end else begin : g_one
    assign sync_d = din;
  end
  assign diff = sync_q[SYNC_STAGES-2] ^ dout_q;
  always_comb begin
    cnt_d  = (!diff || cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    dout_d = (diff && cnt_q == CNT_LAST) ? ~dout_q : dout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end
  assign dout = dout_q;
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: holds N reset domains until PLL lock is stable for HOLD_CYCLES, then releases them
// STAGE_GAP cycles apart; any abort (lock loss, button, software request) restarts the sequence.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int          N_DOMAINS       = 3,
  parameter int          HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int          STAGE_GAP       = 16,
  parameter int          DEBOUNCE_CYCLES = 65536,
  parameter logic [31:0] TIMEOUT         = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 btn_rst,
  input  logic                 sw_rst_req,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 all_released,
  output logic                 sim_done,
  output logic [1:0]           state_dbg
);
  localparam int            HW        = $clog2(HOLD_CYCLES + 1);
  localparam int            SW        = $clog2(STAGE_GAP + 1);
  localparam int            DW        = $clog2(N_DOMAINS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] GAP_LAST  = SW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] DOM_LAST  = DW'(N_DOMAINS - 1);
  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [DW-1:0]          dom_q, dom_d;
  logic [N_DOMAINS-1:0]   rst_n_q, rst_n_d;
  logic                   all_q, all_d;
  logic [31:0]            cyc_q, cyc_d;
  logic                   done_q, done_d;
  logic                   locked_sync, btn_db, ok;
  sync_debounce #(.DEBOUNCE_CYCLES(1)) u_pll_sync (
    .clk (clk),
    .rst (rst),
    .din (pll_locked),
    .dout(locked_sync)
  );
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk (clk),
    .rst (rst),
    .din (btn_rst),
    .dout(btn_db)
  );
  assign ok = locked_sync & ~btn_db & ~sw_rst_req;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stage_d = stage_q;
    dom_d   = dom_q;
    rst_n_d = rst_n_q;
    all_d   = all_q;
    case (state_q)
      ST_ASSERT: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = (N_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
          rst_n_d[0] = 1'b1;
          all_d      = (N_DOMAINS == 1);
          dom_d      = DW'(1);
          hold_d     = '0;
          stage_d    = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (stage_q == GAP_LAST) begin
          rst_n_d[dom_q] = 1'b1;
          dom_d          = dom_q + DW'(1);
          stage_d        = '0;
          state_d        = (dom_q == DOM_LAST) ? ST_RUN : ST_RELEASE;
          all_d          = (dom_q == DOM_LAST);
        end else begin
          stage_d = stage_q + SW'(1);
        end
      end
      default: ;
    endcase
    // Abort overrides whatever the case above decided, including a release due this cycle.
    if (!ok) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      stage_d = '0;
      dom_d   = '0;
      rst_n_d = '0;
      all_d   = 1'b0;
    end
    cyc_d  = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    done_d = done_q | ((TIMEOUT != 32'd0) && (cyc_q == TIMEOUT - 32'd1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      stage_q <= '0;
      dom_q   <= '0;
      rst_n_q <= '0;
      all_q   <= 1'b0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stage_q <= stage_d;
      dom_q   <= dom_d;
      rst_n_q <= rst_n_d;
      all_q   <= all_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
    end
  end
  assign rst_n_out    = rst_n_q;
  assign all_released = all_q;
  assign sim_done     = done_q;
  assign state_dbg    = state_q;
endmodule
